// File: rtl/reg_file_if.sv
// Register-file access bundle: two combinational read ports plus one write-back port.
// The master side is the pipeline (ID reads, WB writes); the slave side is the register file.
interface reg_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] read_addr_1;
    logic [ADDR_WIDTH-1:0] read_addr_2;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_en;

    modport master (
        output read_addr_1,
        output read_addr_2,
        input  read_data_1,
        input  read_data_2,
        output write_addr,
        output write_data,
        output write_en
    );

    modport slave (
        input  read_addr_1,
        input  read_addr_2,
        output read_data_1,
        output read_data_2,
        input  write_addr,
        input  write_data,
        input  write_en
    );
endinterface

// File: rtl/reg_file.sv
// Two-read, one-write MIPS register file with r0 hardwired to zero and same-cycle
// write-through bypass on both read ports.
module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);
    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [Depth];
    logic                  write_ok;

    // Writes to r0 are dropped so the stored r0 never leaves zero.
    assign write_ok = bus.write_en && (bus.write_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_ok) begin
            regs_q[bus.write_addr] <= bus.write_data;
        end
    end

    // Priority: reset, r0, bypass of the in-flight write, then storage.
    always_comb begin
        bus.read_data_1 = regs_q[bus.read_addr_1];
        if (rst || (bus.read_addr_1 == '0)) begin
            bus.read_data_1 = '0;
        end else if (bus.write_en && (bus.write_addr == bus.read_addr_1)) begin
            bus.read_data_1 = bus.write_data;
        end
    end

    always_comb begin
        bus.read_data_2 = regs_q[bus.read_addr_2];
        if (rst || (bus.read_addr_2 == '0)) begin
            bus.read_data_2 = '0;
        end else if (bus.write_en && (bus.write_addr == bus.read_addr_2)) begin
            bus.read_data_2 = bus.write_data;
        end
    end
endmodule
